axi_llc_sram_arb: RTL and testbench
===================================

Name: axi_llc_sram_arb

Overview:
- Shares one LLC data/tag SRAM port, including its ECC wrapper, between NumReq requesters, such as the refill, eviction and hit/miss units.
- Arbitrates round-robin and forwards the winner to the SRAM.
- Tracks in-flight reads through the fixed read latency and routes the read-valid back to the issuing requester.
- Also schedules periodic ECC scrub triggers and counts reported ECC errors.

Parameters:
- NumReq, 3, number of requesters (>=2).
- AddrWidth, 10, SRAM word address width.
- DataWidth, 128, SRAM data width.
- BeWidth, 16, byte-enable width.
- RdLatency, 1, cycles from SRAM handshake to valid rdata; equals NumOutputCuts+1 of the SRAM (>=1).
- NumBanks, 1, number of ECC banks (scrub/error vector width).
- ScrubInterval, 1024, cycles between scrub trigger pulses; 0 disables scrubbing.
- CntWidth, 16, width of the error counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NumReq  per-requester request
- we_i  in  NumReq  per-requester write enable
- addr_i  in  NumReq*AddrWidth  per-requester address
- wdata_i  in  NumReq*DataWidth  per-requester write data
- be_i  in  NumReq*BeWidth  per-requester byte enable
- gnt_o  out  NumReq  one-hot grant (handshake)
- rvalid_o  out  NumReq  one-hot read-data valid
- rdata_o  out  DataWidth  read data, shared by all requesters
- sram_req_o  out  1  SRAM request
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  AddrWidth  SRAM address
- sram_wdata_o  out  DataWidth  SRAM write data
- sram_be_o  out  BeWidth  SRAM byte enable
- sram_gnt_i  in  1  SRAM ready
- sram_rdata_i  in  DataWidth  SRAM read data
- scrub_trigger_o  out  NumBanks  scrub pulse to the ECC banks
- single_error_i  in  NumBanks  single-bit error reports
- multi_error_i  in  NumBanks  multi-bit error reports
- err_clr_i  in  1  synchronous clear of both error counters
- single_err_cnt_o  out  CntWidth  single-error count
- multi_err_cnt_o  out  CntWidth  multi-error count

Behaviour:
- Arbitration:
  - Combinational round-robin. The search starts at pointer rr_q and the first requester with req_i=1 wins.
  - sram_req_o = |req_i. Winner's we/addr/wdata/be are muxed to the sram_* outputs.
  - gnt_o[winner] = sram_gnt_i; all other gnt_o bits are 0.
  - Handshake = sram_req_o & sram_gnt_i.
  - On a handshake, rr_q <= (winner+1) mod NumReq. Otherwise rr_q holds. Reset value of rr_q is 0.
- Requester rule: after asserting req_i, a requester keeps req/we/addr/wdata/be stable until its gnt_o. The arbiter never revokes a winner while sram_gnt_i=0 (rr_q does not move).
- Read tracking:
  - A shift pipeline of depth RdLatency carries {valid, id}. It captures valid = handshake & ~sram_we_o and id = winner.
  - rvalid_o[id] is asserted exactly RdLatency cycles after the read handshake, for one cycle.
  - Writes produce no rvalid_o.
  - rdata_o = sram_rdata_i, passed through combinationally.
  - Back-to-back reads from different requesters are supported every cycle.
- Scrub scheduling:
  - Down-counter, reset to ScrubInterval-1, decrements every cycle.
  - At 0 it pulses scrub_trigger_o = all-ones for one cycle and reloads ScrubInterval-1.
  - ScrubInterval=0 holds scrub_trigger_o at 0.
- Error counters:
  - single_err_cnt_o increments by 1 in each cycle with |single_error_i; multi_err_cnt_o likewise with |multi_error_i.
  - Both saturate at all-ones.
  - err_clr_i zeroes both and has priority over an increment in the same cycle.
- Reset values: rr_q=0, tracking pipeline invalid, rvalid_o=0, scrub_trigger_o=0, counters=0. sram_req_o/gnt_o follow inputs combinationally.
- Reset mid-operation: in-flight reads are dropped and no rvalid_o is emitted for them.

Optional Feature:
- Macro: AXI_LLC_SRAM_ARB_WR_PRIO_EN.
- Defined: if any requester has req_i & we_i, round-robin runs over write requesters only. Reads are considered only when no write is pending. rr_q is shared and updated as usual.
- Undefined: plain round-robin over all requests regardless of we_i.

Test Plan:
- NumReq=3, all req_i=1 held, all reads, sram_gnt_i=1 -> gnt_o sequence 001,010,100,001. rvalid_o follows the same sequence delayed RdLatency=1 cycle.
- Req0 read at addr 5, sram_gnt_i=0 for 3 cycles then 1 -> gnt_o[0] only in cycle 4, rr_q moves 0->1 only then, rvalid_o[0] in cycle 5.
- Req1 write (be=16'hFFFF) then req2 read, back-to-back -> sram_we_o=1 then 0, rvalid_o[2] only, no rvalid_o[1].
- ScrubInterval=4 -> scrub_trigger_o pulses at cycles 4, 8, 12 after reset release. ScrubInterval=0 -> never pulses.
- single_error_i=1 for 5 cycles, with err_clr_i=1 in cycle 3 -> single_err_cnt_o ends at 2. With CntWidth=2 and 6 errors -> saturates at 3.
- With AXI_LLC_SRAM_ARB_WR_PRIO_EN defined: req0 read and req1 write pending, rr_q=0 -> gnt_o=010 first, then 001. Without the macro -> 001 then 010.

Source files
------------

// File: rtl/axi_llc_sram_arb.sv
// rtl/axi_llc_sram_arb.sv - round-robin arbiter sharing one LLC SRAM port, with read routing, scrub pulses and ECC error counters
// Optional write priority: define AXI_LLC_SRAM_ARB_WR_PRIO_EN.
module axi_llc_sram_arb #(
    parameter int NumReq        = 3,
    parameter int AddrWidth     = 10,
    parameter int DataWidth     = 128,
    parameter int BeWidth       = 16,
    parameter int RdLatency     = 1,
    parameter int NumBanks      = 1,
    parameter int ScrubInterval = 1024,
    parameter int CntWidth      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq-1:0]             we_i,
    input  logic [NumReq*AddrWidth-1:0]   addr_i,
    input  logic [NumReq*DataWidth-1:0]   wdata_i,
    input  logic [NumReq*BeWidth-1:0]     be_i,
    output logic [NumReq-1:0]             gnt_o,
    output logic [NumReq-1:0]             rvalid_o,
    output logic [DataWidth-1:0]          rdata_o,
    output logic                          sram_req_o,
    output logic                          sram_we_o,
    output logic [AddrWidth-1:0]          sram_addr_o,
    output logic [DataWidth-1:0]          sram_wdata_o,
    output logic [BeWidth-1:0]            sram_be_o,
    input  logic                          sram_gnt_i,
    input  logic [DataWidth-1:0]          sram_rdata_i,
    output logic [NumBanks-1:0]           scrub_trigger_o,
    input  logic [NumBanks-1:0]           single_error_i,
    input  logic [NumBanks-1:0]           multi_error_i,
    input  logic                          err_clr_i,
    output logic [CntWidth-1:0]           single_err_cnt_o,
    output logic [CntWidth-1:0]           multi_err_cnt_o
);
    localparam int IdxW = $clog2(NumReq);

    logic [IdxW-1:0]   rr_q;
    logic [IdxW-1:0]   winner;
    logic [NumReq-1:0] cand;
    logic              found;
    logic              handshake;
    int                idx;

    always_comb begin
        cand = req_i;
`ifdef AXI_LLC_SRAM_ARB_WR_PRIO_EN
        if (|(req_i & we_i)) begin
            cand = req_i & we_i;
        end
`endif
    end

    // Winner stays put while sram_gnt_i is low because rr_q only moves on a handshake.
    always_comb begin
        winner = rr_q;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NumReq; k++) begin
            idx = (int'(rr_q) + k) % NumReq;
            if (!found && cand[idx]) begin
                winner = IdxW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign sram_req_o   = |req_i;
    assign sram_we_o    = we_i[winner];
    assign sram_addr_o  = addr_i[int'(winner)*AddrWidth +: AddrWidth];
    assign sram_wdata_o = wdata_i[int'(winner)*DataWidth +: DataWidth];
    assign sram_be_o    = be_i[int'(winner)*BeWidth +: BeWidth];
    assign handshake    = sram_req_o & sram_gnt_i;
    assign rdata_o      = sram_rdata_i;

    always_comb begin
        gnt_o         = '0;
        gnt_o[winner] = handshake;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (handshake) begin
            rr_q <= (int'(winner) == NumReq - 1) ? '0 : winner + 1'b1;
        end
    end

    logic [RdLatency-1:0] pipe_vld;
    logic [IdxW-1:0]      pipe_id [RdLatency];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld <= '0;
            for (int i = 0; i < RdLatency; i++) begin
                pipe_id[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= handshake & ~sram_we_o;
            pipe_id[0]  <= winner;
            for (int i = 1; i < RdLatency; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        if (pipe_vld[RdLatency-1]) begin
            rvalid_o[pipe_id[RdLatency-1]] = 1'b1;
        end
    end

    generate
        if (ScrubInterval == 0) begin : g_no_scrub
            assign scrub_trigger_o = '0;
        end else begin : g_scrub
            localparam int ScrubW = (ScrubInterval > 1) ? $clog2(ScrubInterval) : 1;
            logic [ScrubW-1:0] scrub_cnt_q;
            logic              scrub_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    scrub_cnt_q <= ScrubW'(ScrubInterval - 1);
                    scrub_q     <= 1'b0;
                end else begin
                    scrub_q     <= (scrub_cnt_q == '0);
                    scrub_cnt_q <= (scrub_cnt_q == '0) ? ScrubW'(ScrubInterval - 1)
                                                       : scrub_cnt_q - 1'b1;
                end
            end

            assign scrub_trigger_o = {NumBanks{scrub_q}};
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            single_err_cnt_o <= '0;
            multi_err_cnt_o  <= '0;
        end else if (err_clr_i) begin
            single_err_cnt_o <= '0;
            multi_err_cnt_o  <= '0;
        end else begin
            if (|single_error_i && single_err_cnt_o != '1) begin
                single_err_cnt_o <= single_err_cnt_o + 1'b1;
            end
            if (|multi_error_i && multi_err_cnt_o != '1) begin
                multi_err_cnt_o <= multi_err_cnt_o + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi_llc_sram_arb.sv
// tb/tb_axi_llc_sram_arb.sv - directed and randomized bench for axi_llc_sram_arb against a behavioural model
module tb_axi_llc_sram_arb;
    localparam int N  = 3;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int L  = 2;
    localparam int NB = 2;
    localparam int SI = 8;
    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk;
    logic              rst_ni;
    logic [N-1:0]      req, we, gnt, rvalid;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [N*BW-1:0]   be;
    logic [DW-1:0]     rdata, sram_wdata, sram_rdata;
    logic              sram_req, sram_we, sram_gnt;
    logic [AW-1:0]     sram_addr;
    logic [BW-1:0]     sram_be;
    logic [NB-1:0]     scrub, single_err, multi_err;
    logic              err_clr;
    logic [CW-1:0]     scnt, mcnt;

    axi_llc_sram_arb #(
        .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW), .RdLatency(L),
        .NumBanks(NB), .ScrubInterval(SI), .CntWidth(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_gnt_i(sram_gnt),
        .sram_rdata_i(sram_rdata), .scrub_trigger_o(scrub), .single_error_i(single_err),
        .multi_error_i(multi_err), .err_clr_i(err_clr), .single_err_cnt_o(scnt),
        .multi_err_cnt_o(mcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rr_m, cyc, s_m, m_m, hs_id;
    logic [N-1:0] exp_rv [4096];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rr_m = 0; cyc = 0; s_m = 0; m_m = 0;
        foreach (exp_rv[i]) exp_rv[i] = '0;
    endtask

    function automatic int m_winner();
        logic [N-1:0] c;
        c = req;
`ifdef AXI_LLC_SRAM_ARB_WR_PRIO_EN
        if (|(req & we)) c = req & we;
`endif
        for (int k = 0; k < N; k++)
            if (c[(rr_m + k) % N]) return (rr_m + k) % N;
        return -1;
    endfunction

    // Called just after a rising edge; checks mid-cycle, then advances the model on the next edge.
    task automatic tick();
        int w;
        logic [N-1:0] eg;
        if (!rst_ni) model_reset();
        #2;
        w  = m_winner();
        eg = '0;
        if (w >= 0 && sram_gnt) eg[w] = 1'b1;
        chk("gnt", gnt, eg);
        chk("sram_req", sram_req, |req);
        if (w >= 0) begin
            chk("sram_we", sram_we, we[w]);
            chk("sram_addr", sram_addr, addr[w*AW +: AW]);
            chk("sram_wdata", sram_wdata, wdata[w*DW +: DW]);
            chk("sram_be", sram_be, be[w*BW +: BW]);
        end
        chk("rdata", rdata, sram_rdata);
        chk("rvalid", rvalid, rst_ni ? exp_rv[cyc] : '0);
        chk("scrub", scrub, (rst_ni && cyc > 0 && cyc % SI == 0) ? {NB{1'b1}} : {NB{1'b0}});
        chk("single_cnt", scnt, rst_ni ? s_m : 0);
        chk("multi_cnt", mcnt, rst_ni ? m_m : 0);
        @(posedge clk);
        hs_id = -1;
        if (rst_ni) begin
            if (w >= 0 && sram_gnt) begin
                hs_id = w;
                rr_m  = (w + 1) % N;
                if (!we[w]) exp_rv[cyc + L][w] = 1'b1;
            end
            if (err_clr) begin
                s_m = 0; m_m = 0;
            end else begin
                if (|single_err && s_m < CMAX) s_m++;
                if (|multi_err && m_m < CMAX) m_m++;
            end
            cyc++;
        end
        #1;
        sram_rdata = $urandom;
    endtask

    task automatic set_req(input int i, input logic w, input int a);
        req[i] = 1'b1;
        we[i]  = w;
        addr[i*AW +: AW]  = AW'(a);
        wdata[i*DW +: DW] = $urandom;
        be[i*BW +: BW]    = BW'($urandom);
    endtask

    initial begin
        rst_ni = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
        sram_gnt = 1'b0; sram_rdata = '0; single_err = '0; multi_err = '0; err_clr = 1'b0;
        model_reset();
        tick(); tick();
        chk("reset_rvalid", rvalid, 3'b000);
        chk("reset_scrub", scrub, 2'b00);
        rst_ni = 1'b1;

        // All three read continuously with SRAM always ready.
        for (int i = 0; i < N; i++) set_req(i, 1'b0, i + 1);
        sram_gnt = 1'b1;
        #1 chk("rr_seq0", gnt, 3'b001); tick();
        #1 chk("rr_seq1", gnt, 3'b010); tick();
        #1 chk("rr_seq2", gnt, 3'b100); tick();
        #1 chk("rr_seq3", gnt, 3'b001); tick();
        req = '0;
        tick(); tick();

        // SRAM stall keeps the winner.
        set_req(0, 1'b0, 5);
        sram_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_gnt", gnt, 3'b000); tick();
        end
        sram_gnt = 1'b1;
        #1 chk("stall_release", gnt, 3'b001); tick();
        req = '0;
        tick(); tick();

        // Write from 1 then read from 2.
        set_req(1, 1'b1, 9); be[BW +: BW] = '1;
        #1 chk("wr_we", sram_we, 1'b1); tick();
        req = '0; set_req(2, 1'b0, 11);
        #1 chk("rd_we", sram_we, 1'b0); tick();
        req = '0;
        tick();
        #1 chk("wr_rd_rvalid", rvalid, 3'b100);
        tick(); tick();

        // Write-versus-read ordering from rr_q = 0.
        rst_ni = 1'b0; tick(); rst_ni = 1'b1;
        set_req(0, 1'b0, 3); set_req(1, 1'b1, 4);
`ifdef AXI_LLC_SRAM_ARB_WR_PRIO_EN
        #1 chk("prio_first", gnt, 3'b010); tick(); req[1] = 1'b0;
        #1 chk("prio_second", gnt, 3'b001); tick(); req[0] = 1'b0;
`else
        #1 chk("prio_first", gnt, 3'b001); tick(); req[0] = 1'b0;
        #1 chk("prio_second", gnt, 3'b010); tick(); req[1] = 1'b0;
`endif
        tick(); tick();

        // Reset with a read in flight drops it.
        set_req(2, 1'b0, 7);
        tick();
        req = '0; rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("reset_drop", rvalid, 3'b000); tick();
        end

        // Error counting with clear, then saturation.
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        single_err = 2'b01;
        for (int i = 0; i < 5; i++) begin
            err_clr = (i == 2); tick();
        end
        err_clr = 1'b0; single_err = '0;
        #1 chk("single_after_clr", scnt, 3'd2);
        multi_err = 2'b10;
        for (int i = 0; i < 10; i++) tick();
        multi_err = '0;
        #1 chk("multi_sat", mcnt, 3'd7);
        tick();

        // Random traffic obeying the hold-until-grant rule.
        for (int c = 0; c < 400; c++) begin
            if (hs_id >= 0) req[hs_id] = 1'b0;
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 1'($urandom), $urandom_range(0, 1023));
            sram_gnt   = ($urandom_range(0, 3) != 0);
            single_err = NB'($urandom_range(0, 3) == 0 ? $urandom : 0);
            multi_err  = NB'($urandom_range(0, 5) == 0 ? $urandom : 0);
            err_clr    = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
